// File: rtl/exe_stage.sv
// Execute stage: Val2 generation, ALU, branch target, {N,Z,C,V} status register, EXE/MEM register.
// Latency: alu_result/wb/mem/store/dest/status registered (1 cycle); branch_taken/branch_address combinational.
// Backpressure: freeze=1 holds the EXE/MEM and status registers; rst (async, active-high) overrides freeze.
//
// Ports: clk, rst, freeze; ID/EX controls (wb_enable_in, mem_read_in, mem_write_in,
// branch_enable_in, S_in, exec_cmd, dest_in, status_in); operands (PC_in, Val_Rn, Val_Rm,
// immediate, shift_operand, signed_imm_24); forwarding (sel_src1, sel_src2, mem_fwd_val,
// wb_fwd_val); outputs branch_taken, branch_address, status_out, wb_enable, mem_read,
// mem_write, alu_result, store_data, dest.
// Optional macro FORWARDING_EN: when defined, sel_src1/sel_src2 choose operands
// (00/11 register, 01 mem_fwd_val, 10 wb_fwd_val); otherwise those ports are ignored.
module exe_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        wb_enable_in,
    input  logic        mem_read_in,
    input  logic        mem_write_in,
    input  logic        branch_enable_in,
    input  logic        S_in,
    input  logic [3:0]  exec_cmd,
    input  logic [31:0] PC_in,
    input  logic [31:0] Val_Rn,
    input  logic [31:0] Val_Rm,
    input  logic        immediate,
    input  logic [11:0] shift_operand,
    input  logic [23:0] signed_imm_24,
    input  logic [3:0]  dest_in,
    input  logic [3:0]  status_in,
    input  logic [1:0]  sel_src1,
    input  logic [1:0]  sel_src2,
    input  logic [31:0] mem_fwd_val,
    input  logic [31:0] wb_fwd_val,
    output logic        branch_taken,
    output logic [31:0] branch_address,
    output logic [3:0]  status_out,
    output logic        wb_enable,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] alu_result,
    output logic [31:0] store_data,
    output logic [3:0]  dest
);

    logic [31:0] op_a;
    logic [31:0] op_b;

`ifdef FORWARDING_EN
    always_comb begin
        case (sel_src1)
            2'b01:   op_a = mem_fwd_val;
            2'b10:   op_a = wb_fwd_val;
            default: op_a = Val_Rn;
        endcase
        case (sel_src2)
            2'b01:   op_b = mem_fwd_val;
            2'b10:   op_b = wb_fwd_val;
            default: op_b = Val_Rm;
        endcase
    end
    logic [1:0] unused_status;
    assign unused_status = status_in[3:2];
`else
    assign op_a = Val_Rn;
    assign op_b = Val_Rm;
    // Forwarding ports stay on the boundary so both builds share one netlist interface.
    logic unused_fwd;
    assign unused_fwd = ^{sel_src1, sel_src2, mem_fwd_val, wb_fwd_val, status_in[3:2]};
`endif

    // Val2 generation
    logic [31:0] imm32;
    logic [4:0]  rot_amt;
    logic [4:0]  sh_amt;
    logic [63:0] imm_dbl;
    logic [63:0] rm_dbl;
    logic [31:0] val2;

    assign imm32   = {24'b0, shift_operand[7:0]};
    assign rot_amt = {shift_operand[11:8], 1'b0};
    // Register-specified shifts are not supported; they degrade to no shift.
    assign sh_amt  = shift_operand[4] ? 5'd0 : shift_operand[11:7];
    // Rotates are done as a right shift of a doubled word.
    assign imm_dbl = {imm32, imm32} >> rot_amt;
    assign rm_dbl  = {op_b, op_b} >> sh_amt;

    always_comb begin
        val2 = 32'b0;
        if (mem_read_in || mem_write_in) begin
            val2 = {20'b0, shift_operand};
        end else if (immediate) begin
            val2 = imm_dbl[31:0];
        end else begin
            case (shift_operand[6:5])
                2'b00:   val2 = op_b << sh_amt;
                2'b01:   val2 = op_b >> sh_amt;
                2'b10:   val2 = $signed(op_b) >>> sh_amt;
                default: val2 = rm_dbl[31:0];
            endcase
        end
    end

    // ALU: add and subtract share one 33-bit adder; subtract uses A + ~Val2 + cin,
    // so the carry-out is directly NOT borrow.
    logic        c_in;
    logic [31:0] add_b;
    logic        add_cin;
    logic [32:0] sum;
    logic        arith;
    logic        known;
    logic [31:0] result;
    logic        flag_c;
    logic        flag_v;

    assign c_in = status_in[1];

    always_comb begin
        add_b   = val2;
        add_cin = 1'b0;
        arith   = 1'b0;
        known   = 1'b1;
        result  = 32'b0;
        case (exec_cmd)
            4'b0010: begin arith = 1'b1; end
            4'b0011: begin arith = 1'b1; add_cin = c_in; end
            4'b0100: begin arith = 1'b1; add_b = ~val2; add_cin = 1'b1; end
            4'b0101: begin arith = 1'b1; add_b = ~val2; add_cin = c_in; end
            default: ;
        endcase
        sum = {1'b0, op_a} + {1'b0, add_b} + {32'b0, add_cin};
        case (exec_cmd)
            4'b0001: result = val2;
            4'b1001: result = ~val2;
            4'b0010, 4'b0011, 4'b0100, 4'b0101: result = sum[31:0];
            4'b0110: result = op_a & val2;
            4'b0111: result = op_a | val2;
            4'b1000: result = op_a ^ val2;
            default: known = 1'b0;
        endcase
    end

    assign flag_c = arith ? sum[32] : status_in[1];
    assign flag_v = arith ? ((op_a[31] == add_b[31]) && (sum[31] != op_a[31])) : status_in[0];

    assign branch_taken   = branch_enable_in;
    assign branch_address = PC_in + {{6{signed_imm_24[23]}}, signed_imm_24, 2'b00};

    // Status register: unlisted opcodes leave the flags untouched even with S set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            status_out <= 4'b0;
        end else if (S_in && known && !freeze) begin
            status_out <= {result[31], (result == 32'b0), flag_c, flag_v};
        end
    end

    // EXE/MEM pipeline register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_enable  <= 1'b0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            alu_result <= 32'b0;
            store_data <= 32'b0;
            dest       <= 4'b0;
        end else if (!freeze) begin
            wb_enable  <= wb_enable_in;
            mem_read   <= mem_read_in;
            mem_write  <= mem_write_in;
            alu_result <= result;
            store_data <= op_b;
            dest       <= dest_in;
        end
    end

endmodule

// File: tb/tb_exe_stage.sv
module tb_exe_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        freeze = 1'b0;
    logic        wb_enable_in = 1'b0, mem_read_in = 1'b0, mem_write_in = 1'b0;
    logic        branch_enable_in = 1'b0, S_in = 1'b0;
    logic [3:0]  exec_cmd = 4'b0;
    logic [31:0] PC_in = 32'b0, Val_Rn = 32'b0, Val_Rm = 32'b0;
    logic        immediate = 1'b0;
    logic [11:0] shift_operand = 12'b0;
    logic [23:0] signed_imm_24 = 24'b0;
    logic [3:0]  dest_in = 4'b0, status_in = 4'b0;
    logic [1:0]  sel_src1 = 2'b0, sel_src2 = 2'b0;
    logic [31:0] mem_fwd_val = 32'b0, wb_fwd_val = 32'b0;

    logic        branch_taken;
    logic [31:0] branch_address;
    logic [3:0]  status_out;
    logic        wb_enable, mem_read, mem_write;
    logic [31:0] alu_result, store_data;
    logic [3:0]  dest;

    exe_stage dut (
        .clk(clk), .rst(rst), .freeze(freeze),
        .wb_enable_in(wb_enable_in), .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
        .branch_enable_in(branch_enable_in), .S_in(S_in), .exec_cmd(exec_cmd),
        .PC_in(PC_in), .Val_Rn(Val_Rn), .Val_Rm(Val_Rm), .immediate(immediate),
        .shift_operand(shift_operand), .signed_imm_24(signed_imm_24), .dest_in(dest_in),
        .status_in(status_in), .sel_src1(sel_src1), .sel_src2(sel_src2),
        .mem_fwd_val(mem_fwd_val), .wb_fwd_val(wb_fwd_val),
        .branch_taken(branch_taken), .branch_address(branch_address), .status_out(status_out),
        .wb_enable(wb_enable), .mem_read(mem_read), .mem_write(mem_write),
        .alu_result(alu_result), .store_data(store_data), .dest(dest)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wb, mr, mw;
        logic [31:0] alu, sd;
        logic [3:0]  dst, st;
    } exp_t;

    exp_t       sb_q[$];
    exp_t       last_exp;
    logic [3:0] model_status = 4'b0;
    int         checks = 0;
    int         errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit ovf(input longint x);
        longint lim;
        lim = 64'sd2147483648;
        return (x >= lim) || (x < -lim);
    endfunction

    function automatic logic [31:0] pick(input logic [1:0] s, input logic [31:0] reg_val);
`ifdef FORWARDING_EN
        if (s == 2'd1) return mem_fwd_val;
        if (s == 2'd2) return wb_fwd_val;
`endif
        return reg_val;
    endfunction

    // Reference model: operands treated as integers, flags from arithmetic ranges.
    function automatic exp_t model();
        exp_t e;
        logic [31:0] a, b, v2, r;
        longint unsigned u;
        longint sa, sv, t;
        logic c, cf, vf, known;
        int n;
        a = pick(sel_src1, Val_Rn);
        b = pick(sel_src2, Val_Rm);
        c = status_in[1];
        if (mem_read_in || mem_write_in) begin
            v2 = 32'(shift_operand);
        end else if (immediate) begin
            n  = 2 * int'(shift_operand[11:8]);
            u  = longint'(shift_operand[7:0]);
            v2 = 32'((u >> n) | (u << (32 - n)));
        end else begin
            n = shift_operand[4] ? 0 : int'(shift_operand[11:7]);
            u = longint'(b);
            case (shift_operand[6:5])
                2'd0: v2 = 32'(u << n);
                2'd1: v2 = 32'(u >> n);
                2'd2: begin sa = longint'($signed(b)); v2 = 32'(sa >>> n); end
                default: v2 = 32'((u >> n) | (u << (32 - n)));
            endcase
        end
        sa = longint'($signed(a));
        sv = longint'($signed(v2));
        cf = status_in[1];
        vf = status_in[0];
        known = 1'b1;
        r = 32'b0;
        case (exec_cmd)
            4'd1: r = v2;
            4'd9: r = ~v2;
            4'd2, 4'd3: begin
                u  = longint'(a) + longint'(v2) + ((exec_cmd == 4'd3) ? longint'(c) : 0);
                r  = 32'(u);
                cf = (u >= 64'h1_0000_0000);
                t  = sa + sv + ((exec_cmd == 4'd3) ? longint'(c) : 0);
                vf = ovf(t);
            end
            4'd4, 4'd5: begin
                t  = (exec_cmd == 4'd5) ? longint'(!c) : 0;
                r  = 32'(longint'(a) - longint'(v2) - t);
                cf = (longint'(a) >= longint'(v2) + t);
                vf = ovf(sa - sv - t);
            end
            4'd6: r = a & v2;
            4'd7: r = a | v2;
            4'd8: r = a ^ v2;
            default: known = 1'b0;
        endcase
        e.wb  = wb_enable_in;
        e.mr  = mem_read_in;
        e.mw  = mem_write_in;
        e.alu = r;
        e.sd  = b;
        e.dst = dest_in;
        e.st  = (S_in && known) ? {r[31], (r == 32'b0), cf, vf} : model_status;
        return e;
    endfunction

    // Called right after a negedge with inputs already set; returns at the next negedge.
    task automatic step();
        exp_t e;
        longint off;
        #1;
        off = longint'(signed_imm_24);
        if (signed_imm_24[23]) off = off - 64'sd16777216;
        chk("branch_taken", 32'(branch_taken), 32'(branch_enable_in));
        chk("branch_address", branch_address, 32'(longint'(PC_in) + off * 4));
        if (!freeze) begin
            e = model();
            sb_q.push_back(e);
            model_status = e.st;
        end
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        {wb_enable_in, mem_read_in, mem_write_in, branch_enable_in, S_in, immediate} = '0;
        exec_cmd = 4'd0; PC_in = 32'd0; Val_Rn = 32'd0; Val_Rm = 32'd0;
        shift_operand = 12'd0; signed_imm_24 = 24'd0; dest_in = 4'd0; status_in = 4'd0;
        sel_src1 = 2'd0; sel_src2 = 2'd0; mem_fwd_val = 32'd0; wb_fwd_val = 32'd0;
        freeze = 1'b0;
    endtask

    // Monitor: a register load happens on each posedge out of reset with freeze low.
    initial begin : monitor
        logic frz, rs;
        exp_t e;
        last_exp = '{default: '0};
        forever begin
            @(posedge clk);
            frz = freeze;
            rs  = rst;
            #1;
            if (rs) begin
                e = '{default: '0};
            end else if (frz) begin
                e = last_exp;
            end else if (sb_q.size() == 0) begin
                chk("scoreboard_empty", 32'd1, 32'd0);
                e = last_exp;
            end else begin
                e = sb_q.pop_front();
            end
            chk("wb_enable", 32'(wb_enable), 32'(e.wb));
            chk("mem_read", 32'(mem_read), 32'(e.mr));
            chk("mem_write", 32'(mem_write), 32'(e.mw));
            chk("alu_result", alu_result, e.alu);
            chk("store_data", store_data, e.sd);
            chk("dest", 32'(dest), 32'(e.dst));
            chk("status_out", 32'(status_out), 32'(e.st));
            last_exp = e;
        end
    end

    initial begin : driver
        clear_inputs();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // ADD imm 0xFF to 5, S set
        exec_cmd = 4'd2; Val_Rn = 32'd5; immediate = 1'b1; shift_operand = 12'h0FF;
        S_in = 1'b1; wb_enable_in = 1'b1; dest_in = 4'd3;
        step();
        // CMP 3,3 -> Z,C
        exec_cmd = 4'd4; Val_Rn = 32'd3; immediate = 1'b1; shift_operand = 12'h003;
        wb_enable_in = 1'b0;
        step();
        // MOV rotated immediate
        exec_cmd = 4'd1; S_in = 1'b0; wb_enable_in = 1'b1; shift_operand = 12'h2FF;
        step();
        // MOV with ASR #1
        immediate = 1'b0; Val_Rm = 32'h8000_0000; shift_operand = 12'h0C0;
        step();
        // Branch
        clear_inputs();
        branch_enable_in = 1'b1; PC_in = 32'h100; signed_imm_24 = 24'hFFFFFE;
        step();
        // Forwarding path (expected value depends on the build)
        clear_inputs();
        exec_cmd = 4'd2; immediate = 1'b1; shift_operand = 12'h001; Val_Rn = 32'd99;
        sel_src1 = 2'b01; mem_fwd_val = 32'd10; wb_enable_in = 1'b1;
        step();
        // Freeze for 3 cycles during an S-flagged ADD, then release
        clear_inputs();
        exec_cmd = 4'd2; Val_Rn = 32'hFFFF_FFFF; immediate = 1'b1; shift_operand = 12'h001;
        S_in = 1'b1; wb_enable_in = 1'b1; dest_in = 4'd7; freeze = 1'b1;
        repeat (3) step();
        freeze = 1'b0;
        step();
        // Reset asserted inside a freeze window
        freeze = 1'b1; Val_Rn = 32'd1;
        step();
        #3 rst = 1'b1;
        #1;
        chk("async_rst_alu", alu_result, 32'd0);
        chk("async_rst_status", 32'(status_out), 32'd0);
        chk("async_rst_wb", 32'(wb_enable), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        sb_q.delete();
        model_status = 4'b0;
        // Flushed bubble
        clear_inputs();
        step();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            freeze           = ($urandom_range(0, 4) == 0);
            exec_cmd         = 4'($urandom_range(0, 15));
            S_in             = 1'($urandom);
            wb_enable_in     = 1'($urandom);
            mem_read_in      = ($urandom_range(0, 5) == 0);
            mem_write_in     = ($urandom_range(0, 5) == 0);
            branch_enable_in = 1'($urandom);
            immediate        = 1'($urandom);
            PC_in            = $urandom;
            Val_Rn           = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
            Val_Rm           = ($urandom_range(0, 3) == 0) ? 32'h7FFF_FFFF : $urandom;
            shift_operand    = 12'($urandom);
            signed_imm_24    = 24'($urandom);
            dest_in          = 4'($urandom);
            status_in        = 4'($urandom);
            sel_src1         = 2'($urandom);
            sel_src2         = 2'($urandom);
            mem_fwd_val      = $urandom;
            wb_fwd_val       = $urandom;
            step();
        end

        // Hold a couple of cycles so the last load is checked, then drain
        freeze = 1'b1;
        repeat (2) @(negedge clk);
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
